// File: rtl/tbman_regs.sv
// tbman_regs: testbench-manager responder (result flag, print FIFO, 64-bit cycle counter).
// Define TBMAN_TIMER_EN to build in the compare timer and irq_timer; otherwise they read as 0.
module tbman_regs #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        CS_TBMAN_N,
  input  logic [31:0] Addr,
  input  logic        WE,
  input  logic [31:0] WData,
  output logic [31:0] RData,
  output logic        test_done,
  output logic        test_pass,
  output logic        putc_valid,
  output logic [7:0]  putc_data,
  input  logic        putc_ready,
  output logic        irq_timer
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  localparam logic [9:0] OFF_RESULT = 10'h000;
  localparam logic [9:0] OFF_PUTC   = 10'h001;
  localparam logic [9:0] OFF_FSTAT  = 10'h002;
  localparam logic [9:0] OFF_CYC_LO = 10'h004;
  localparam logic [9:0] OFF_CYC_HI = 10'h005;
`ifdef TBMAN_TIMER_EN
  localparam logic [9:0] OFF_TCMP   = 10'h006;
  localparam logic [9:0] OFF_TCTRL  = 10'h007;
`endif

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [9:0]  idx;
    logic [31:0] wdata;
  } req_t;

  req_t req;
  always_comb begin
    req.rd    = !CS_TBMAN_N && !WE;
    req.wr    = !CS_TBMAN_N && WE;
    req.idx   = Addr[11:2];
    req.wdata = WData;
  end

  logic unused_bits;
  assign unused_bits = ^{Addr[31:12], Addr[1:0], req.wdata[31:8]};

  logic [63:0] cycle_cnt;
  logic [31:0] hi_shadow;
  logic [31:0] rd_data;

  // Print FIFO: power-of-two depth lets the pointers wrap naturally.
  logic [FIFO_DEPTH-1:0][7:0] fifo_mem;
  logic [PW-1:0]              wr_ptr, rd_ptr;
  logic [CW-1:0]              count;
  logic                       overflow;
  logic                       fifo_full, fifo_empty, pop, push_req, push;

  assign fifo_full  = (count == CW'(FIFO_DEPTH));
  assign fifo_empty = (count == '0);
  assign putc_valid = !fifo_empty;
  assign putc_data  = fifo_empty ? 8'h00 : fifo_mem[rd_ptr];
  assign pop        = putc_valid && putc_ready;
  assign push_req   = req.wr && (req.idx == OFF_PUTC);
  // A same-cycle pop frees the slot, so a push into a full FIFO still lands.
  assign push       = push_req && (!fifo_full || pop);

`ifdef TBMAN_TIMER_EN
  logic [31:0] timer_cmp;
  logic        timer_en, timer_pend, timer_hit, timer_clr;

  assign timer_hit = timer_en && (cycle_cnt[31:0] == timer_cmp);
  assign timer_clr = req.wr && (req.idx == OFF_TCTRL) && req.wdata[1];
  assign irq_timer = timer_pend;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer_cmp  <= '0;
      timer_en   <= 1'b0;
      timer_pend <= 1'b0;
    end else begin
      if (req.wr && req.idx == OFF_TCMP)  timer_cmp <= req.wdata;
      if (req.wr && req.idx == OFF_TCTRL) timer_en  <= req.wdata[0];
      if (timer_hit)      timer_pend <= 1'b1;
      else if (timer_clr) timer_pend <= 1'b0;
    end
  end
`else
  assign irq_timer = 1'b0;
`endif

  always_comb begin
    rd_data = '0;
    case (req.idx)
      OFF_RESULT: rd_data = {30'b0, test_pass, test_done};
      OFF_FSTAT:  rd_data = {24'b0, 4'(count), 1'b0, overflow, fifo_full, fifo_empty};
      OFF_CYC_LO: rd_data = cycle_cnt[31:0];
      OFF_CYC_HI: rd_data = hi_shadow;
`ifdef TBMAN_TIMER_EN
      OFF_TCMP:   rd_data = timer_cmp;
      OFF_TCTRL:  rd_data = {30'b0, timer_pend, timer_en};
`endif
      default:    rd_data = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= req.wdata[7:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      RData     <= '0;
      test_done <= 1'b0;
      test_pass <= 1'b0;
      cycle_cnt <= '0;
      hi_shadow <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
    end else begin
      cycle_cnt <= cycle_cnt + 64'd1;
      if (req.rd) RData <= rd_data;
      // Latch the upper half with the low read so a LO-then-HI pair is coherent.
      if (req.rd && req.idx == OFF_CYC_LO) hi_shadow <= cycle_cnt[63:32];
      if (req.wr && req.idx == OFF_RESULT && !test_done) begin
        test_done <= 1'b1;
        test_pass <= req.wdata[0];
      end
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
      if (push_req && !push)
        overflow <= 1'b1;
      else if (req.wr && req.idx == OFF_FSTAT && req.wdata[2])
        overflow <= 1'b0;
    end
  end
endmodule
